// File: rtl/nios_system_led_pio_if.sv
`default_nettype none
// ============================================================================
// Module      : nios_system_led_pio_if
// Description : Avalon-MM slave bus bundle for the LED PIO register block.
// Revision    : 1.0 - initial release
// ============================================================================
interface nios_system_led_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/nios_system_led_pio.sv
`default_nettype none
// ============================================================================
// Module      : nios_system_led_pio
// Description : Avalon-MM LED output port with set/clear/toggle aliases and an
//               optional per-bit blink engine (enabled by LED_PIO_BLINK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module nios_system_led_pio #(
    parameter int               WIDTH       = 18,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               PRESCALE_W  = 24
) (
    input  wire logic             clk,
    input  wire logic             reset,
    nios_system_led_pio_if.slave  bus,
    output logic [WIDTH-1:0]      out_port
);

    localparam logic [2:0] c_ADDR_DATA     = 3'd0;
    localparam logic [2:0] c_ADDR_MASK     = 3'd1;
    localparam logic [2:0] c_ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] c_ADDR_TOGGLE   = 3'd3;
    localparam logic [2:0] c_ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] c_ADDR_OUTCLEAR = 3'd5;
    localparam logic [2:0] c_ADDR_STATUS   = 3'd6;

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] r_data;
    logic             w_unused_wd;

    assign w_wr        = bus.chipselect & ~bus.write_n;
    assign w_wd        = bus.writedata[WIDTH-1:0];
    assign w_unused_wd = ^bus.writedata;

    // DATA and its three read-modify-write aliases share one register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= RESET_VALUE;
        end else if (w_wr) begin
            case (bus.address)
                c_ADDR_DATA:     r_data <= w_wd;
                c_ADDR_TOGGLE:   r_data <= r_data ^ w_wd;
                c_ADDR_OUTSET:   r_data <= r_data | w_wd;
                c_ADDR_OUTCLEAR: r_data <= r_data & ~w_wd;
                default:         r_data <= r_data;
            endcase
        end
    end

`ifdef LED_PIO_BLINK_EN
    logic [WIDTH-1:0]      r_mask;
    logic [PRESCALE_W-1:0] r_period;
    logic [PRESCALE_W-1:0] r_count;
    logic                  r_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
        end else if (w_wr && (bus.address == c_ADDR_MASK)) begin
            r_mask <= w_wd;
        end
    end

    // A PERIOD write restarts the blink cycle and takes priority over a wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period <= '0;
            r_count  <= '0;
            r_phase  <= 1'b1;
        end else if (w_wr && (bus.address == c_ADDR_PERIOD)) begin
            r_period <= bus.writedata[PRESCALE_W-1:0];
            r_count  <= '0;
            r_phase  <= 1'b1;
        end else if (r_period == '0) begin
            r_count  <= '0;
            r_phase  <= 1'b1;
        end else if (r_count == r_period) begin
            r_count  <= '0;
            r_phase  <= ~r_phase;
        end else begin
            r_count  <= r_count + PRESCALE_W'(1);
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            c_ADDR_DATA:   bus.readdata[WIDTH-1:0]      = r_data;
            c_ADDR_MASK:   bus.readdata[WIDTH-1:0]      = r_mask;
            c_ADDR_PERIOD: bus.readdata[PRESCALE_W-1:0] = r_period;
            c_ADDR_STATUS: bus.readdata[0]              = r_phase;
            default:       bus.readdata                 = '0;
        endcase
    end

    assign out_port = r_data & (~r_mask | {WIDTH{r_phase}});
`else
    always_comb begin
        bus.readdata = '0;
        if (bus.address == c_ADDR_DATA) begin
            bus.readdata[WIDTH-1:0] = r_data;
        end
    end

    assign out_port = r_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nios_system_led_pio.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios_system_led_pio
// Description : Scoreboard bench for nios_system_led_pio against a cycle-count
//               reference model of the register map and blink timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios_system_led_pio;

    localparam int          c_WIDTH = 18;
    localparam logic [17:0] c_RV    = 18'h000F0;
`ifdef LED_PIO_BLINK_EN
    localparam bit c_BLINK = 1'b1;
`else
    localparam bit c_BLINK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [c_WIDTH-1:0] out_port;

    nios_system_led_pio_if bus_if ();

    nios_system_led_pio #(
        .WIDTH       (c_WIDTH),
        .RESET_VALUE (c_RV),
        .PRESCALE_W  (24)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_if.slave),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]         a;
        logic [31:0]        rd;
        logic [c_WIDTH-1:0] out;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: register contents plus edges elapsed since the
    // blink cycle last restarted; phase is derived arithmetically from that.
    logic [17:0] m_data;
    logic [17:0] m_mask;
    logic [23:0] m_period;
    longint      m_k;

    function automatic bit m_phase();
        if (!c_BLINK || m_period == 0) return 1'b1;
        return ((m_k / (longint'(m_period) + 1)) % 2) == 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return {14'd0, m_data};
            3'd1: return c_BLINK ? {14'd0, m_mask} : 32'd0;
            3'd2: return c_BLINK ? {8'd0, m_period} : 32'd0;
            3'd6: return c_BLINK ? {31'd0, m_phase()} : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [17:0] m_out();
        if (!c_BLINK) return m_data;
        return m_phase() ? m_data : (m_data & ~m_mask);
    endfunction

    task automatic m_step(input bit rst, input bit wr, input logic [2:0] a, input logic [31:0] wd);
        if (rst) begin
            m_data = c_RV; m_mask = '0; m_period = '0; m_k = 0;
            return;
        end
        if (m_period != 0) m_k++;
        if (wr) begin
            case (a)
                3'd0: m_data = wd[17:0];
                3'd1: if (c_BLINK) m_mask = wd[17:0];
                3'd2: if (c_BLINK) begin m_period = wd[23:0]; m_k = 0; end
                3'd3: m_data = m_data ^ wd[17:0];
                3'd4: m_data = m_data | wd[17:0];
                3'd5: m_data = m_data & ~wd[17:0];
                default: ;
            endcase
        end
    endtask

    task automatic cyc(input bit rst, input bit wr, input bit rd, input logic [2:0] a, input logic [31:0] wd);
        exp_t e;
        @(posedge clk);
        #1;
        reset                = rst;
        bus_if.chipselect    = wr | rd;
        bus_if.write_n       = ~wr;
        bus_if.address       = a;
        bus_if.writedata     = wd;
        if (rd && !wr && !rst) begin
            e.a   = a;
            e.rd  = m_read(a);
            e.out = m_out();
            exp_q.push_back(e);
        end
        m_step(rst, wr, a, wd);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
        cyc(1'b0, 1'b1, 1'b0, a, wd);
    endtask

    task automatic rd_reg(input logic [2:0] a);
        cyc(1'b0, 1'b0, 1'b1, a, 32'd0);
    endtask

    // Monitor: every read access presented to the DUT is scored at negedge.
    always @(negedge clk) begin
        if (bus_if.chipselect && bus_if.write_n && !reset) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL underflow: read at addr %0d with no expectation queued", bus_if.address);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_checks++;
                if (bus_if.readdata === e.rd) n_pass++;
                else $display("FAIL readdata addr %0d: got %h want %h", e.a, bus_if.readdata, e.rd);
                n_checks++;
                if (out_port === e.out) n_pass++;
                else $display("FAIL out_port (read addr %0d): got %h want %h", e.a, out_port, e.out);
            end
        end
    end

    initial begin
        bus_if.address    = '0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = '0;
        m_step(1'b1, 1'b0, 3'd0, 32'd0);

        // Reset values, with a write during reset that must be discarded.
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 32'h0001_2345);
        rd_reg(3'd0); rd_reg(3'd6); rd_reg(3'd1); rd_reg(3'd2);

        // Alias sequence on DATA, including upper-bit truncation.
        wr_reg(3'd0, 32'h0003_FFFF); rd_reg(3'd0);
        wr_reg(3'd5, 32'h0000_000F); rd_reg(3'd0);
        wr_reg(3'd4, 32'h0000_0003); rd_reg(3'd0);
        wr_reg(3'd3, 32'h0003_0000); rd_reg(3'd0);
        wr_reg(3'd0, 32'hFFFF_FFFF); rd_reg(3'd0);
        for (int a = 3; a < 8; a++) rd_reg(3'(a));

        // Blink: DATA=3, mask bit 0, PERIOD=4, observed each cycle.
        wr_reg(3'd0, 32'd3); wr_reg(3'd1, 32'd1); wr_reg(3'd2, 32'd4);
        for (int i = 0; i < 24; i++) rd_reg(3'd6);
        // Restart mid-cycle with a shorter period.
        wr_reg(3'd2, 32'd2);
        for (int i = 0; i < 12; i++) rd_reg(3'd1 + 3'(i % 2) * 3'd5);
        wr_reg(3'd0, 32'd1);
        rd_reg(3'd0); rd_reg(3'd2);
        // Reset mid-blink aborts the cycle.
        cyc(1'b1, 1'b1, 1'b0, 3'd2, 32'd7);
        rd_reg(3'd6); rd_reg(3'd0); rd_reg(3'd2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int unsigned op;
            logic [2:0]  a;
            logic [31:0] wd;
            op = $urandom_range(0, 99);
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd2) wd = ($urandom_range(0, 9) == 0) ? 32'(wd[24:0]) : 32'($urandom_range(0, 6));
            if (op < 1)       cyc(1'b1, op[0], 1'b0, a, wd);
            else if (op < 35) wr_reg(a, wd);
            else              rd_reg(a);
        end

        cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
